// File: rtl/arkanoid_pkg.sv
// Shared geometry and FSM encoding for the Arkanoid ball/brick/paddle logic.
// All pixel coordinates are carried as 13-bit unsigned so ball-box edges never wrap.
package arkanoid_pkg;

  localparam int BALL_R     = 10;
  localparam int GRID_X0    = 256;
  localparam int GRID_Y0    = 96;
  localparam int BRICK_W    = 64;
  localparam int BRICK_H    = 24;
  localparam int PADDLE_W   = 128;
  localparam int PADDLE_Y   = 740;
  localparam int PADDLE_H   = 12;
  localparam int GRID_COLS  = 4;
  localparam int GRID_ROWS  = 4;
  localparam int SCREEN_W   = 1024;
  localparam int NUM_BRICKS = GRID_COLS * GRID_ROWS;

  localparam logic [3:0]  LAST_IDX = 4'(NUM_BRICKS - 1);
  localparam logic [11:0] RESET_X  = 12'd300;
  localparam logic [11:0] RESET_Y  = 12'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_PADDLE = 2'd2,
    ST_COMMIT = 2'd3
  } coll_state_e;

  // Brick index i = row*4 + col, so col is idx[1:0] and row is idx[3:2].
  function automatic logic [12:0] brick_x0(input logic [3:0] idx);
    return 13'(GRID_X0) + 13'(BRICK_W) * {11'd0, idx[1:0]};
  endfunction

  function automatic logic [12:0] brick_y0(input logic [3:0] idx);
    return 13'(GRID_Y0) + 13'(BRICK_H) * {11'd0, idx[3:2]};
  endfunction

  function automatic logic [12:0] box_lo(input logic [11:0] p);
    return ({1'b0, p} < 13'(BALL_R)) ? 13'd0 : ({1'b0, p} - 13'(BALL_R));
  endfunction

  function automatic logic [12:0] box_hi(input logic [11:0] p);
    return {1'b0, p} + 13'(BALL_R);
  endfunction

endpackage

// File: rtl/ball_collision_det_if.sv
// Position/paddle inputs and collision results exchanged between the game
// logic (master) and ball_collision_det (slave).
interface ball_collision_det_if;

  logic        new_game;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [11:0] paddle_x;
  logic [15:0] collision_det;
  logic [15:0] coll_y_det;
  logic        paddle_hit;
  logic [15:0] brick_alive;
  logic        all_cleared;
  logic        scan_done;

  modport master (
    output new_game, x_pos, y_pos, paddle_x,
    input  collision_det, coll_y_det, paddle_hit, brick_alive, all_cleared, scan_done
  );

  modport slave (
    input  new_game, x_pos, y_pos, paddle_x,
    output collision_det, coll_y_det, paddle_hit, brick_alive, all_cleared, scan_done
  );

endinterface

// File: rtl/rect_overlap.sv
// Inclusive-edge intersection of the ball box with one rectangle, plus whether
// the ball centre lies inside the rectangle's vertical span.
module rect_overlap (
  input  logic [12:0] bx0,
  input  logic [12:0] bx1,
  input  logic [12:0] by0,
  input  logic [12:0] by1,
  input  logic [12:0] cy,
  input  logic [12:0] rx0,
  input  logic [12:0] rx1,
  input  logic [12:0] ry0,
  input  logic [12:0] ry1,
  output logic        overlap,
  output logic        centre_in_yspan
);

  assign overlap = (bx0 <= rx1) && (bx1 >= rx0) && (by0 <= ry1) && (by1 >= ry0);
  assign centre_in_yspan = (cy >= ry0) && (cy <= ry1);

endmodule

// File: rtl/ball_collision_det.sv
// Scans the 4x4 brick grid and the paddle against a latched ball position, one
// rectangle per cycle, and commits the hit vectors and brick-alive map together.
module ball_collision_det
  import arkanoid_pkg::*;
(
  input  logic                 pclk,
  input  logic                 reset_n,
  ball_collision_det_if.slave  bus
);

  coll_state_e state_r;
  logic [3:0]  idx_r;
  logic [11:0] lat_x_r;
  logic [11:0] lat_y_r;
  logic [15:0] scr_side_r;
  logic [15:0] scr_face_r;
  logic        scr_paddle_r;
  logic [15:0] coll_side_r;
  logic [15:0] coll_face_r;
  logic        paddle_hit_r;
  logic [15:0] alive_r;
  logic        all_cleared_r;
  logic        scan_done_r;

  logic [12:0] rx0_s, rx1_s, ry0_s, ry1_s;
  logic        ovl_s;
  logic        cy_in_s;
  logic        moved_s;
  logic        restart_s;
  logic [15:0] alive_next_s;

  assign moved_s      = (bus.x_pos != lat_x_r) || (bus.y_pos != lat_y_r);
  // A commit is never aborted; a move seen in COMMIT is picked up from IDLE.
  assign restart_s    = moved_s && (state_r != ST_COMMIT);
  assign alive_next_s = alive_r & ~(scr_side_r | scr_face_r);

  // Rectangle under test: the paddle in PADDLE, otherwise the brick at idx_r.
  always_comb begin
    rx0_s = brick_x0(idx_r);
    rx1_s = brick_x0(idx_r) + 13'(BRICK_W - 1);
    ry0_s = brick_y0(idx_r);
    ry1_s = brick_y0(idx_r) + 13'(BRICK_H - 1);
    case (state_r)
      ST_PADDLE: begin
        rx0_s = {1'b0, bus.paddle_x};
        rx1_s = {1'b0, bus.paddle_x} + 13'(PADDLE_W - 1);
        ry0_s = 13'(PADDLE_Y);
        ry1_s = 13'(PADDLE_Y + PADDLE_H - 1);
      end
      default: begin
        rx0_s = brick_x0(idx_r);
        rx1_s = brick_x0(idx_r) + 13'(BRICK_W - 1);
        ry0_s = brick_y0(idx_r);
        ry1_s = brick_y0(idx_r) + 13'(BRICK_H - 1);
      end
    endcase
  end

  rect_overlap u_rect_overlap (
    .bx0             (box_lo(lat_x_r)),
    .bx1             (box_hi(lat_x_r)),
    .by0             (box_lo(lat_y_r)),
    .by1             (box_hi(lat_y_r)),
    .cy              ({1'b0, lat_y_r}),
    .rx0             (rx0_s),
    .rx1             (rx1_s),
    .ry0             (ry0_s),
    .ry1             (ry1_s),
    .overlap         (ovl_s),
    .centre_in_yspan (cy_in_s)
  );

  // Scan FSM with scratch accumulation and registered result outputs.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= 4'd0;
      lat_x_r       <= RESET_X;
      lat_y_r       <= RESET_Y;
      scr_side_r    <= 16'h0000;
      scr_face_r    <= 16'h0000;
      scr_paddle_r  <= 1'b0;
      coll_side_r   <= 16'h0000;
      coll_face_r   <= 16'h0000;
      paddle_hit_r  <= 1'b0;
      alive_r       <= 16'hFFFF;
      all_cleared_r <= 1'b0;
      scan_done_r   <= 1'b0;
    end else if (bus.new_game) begin
      // Latched position is deliberately kept so only a real move rescans.
      state_r       <= ST_IDLE;
      idx_r         <= 4'd0;
      scr_side_r    <= 16'h0000;
      scr_face_r    <= 16'h0000;
      scr_paddle_r  <= 1'b0;
      coll_side_r   <= 16'h0000;
      coll_face_r   <= 16'h0000;
      paddle_hit_r  <= 1'b0;
      alive_r       <= 16'hFFFF;
      all_cleared_r <= 1'b0;
      scan_done_r   <= 1'b0;
    end else begin
      scan_done_r <= 1'b0;
      if (restart_s) begin
        lat_x_r      <= bus.x_pos;
        lat_y_r      <= bus.y_pos;
        scr_side_r   <= 16'h0000;
        scr_face_r   <= 16'h0000;
        scr_paddle_r <= 1'b0;
        idx_r        <= 4'd0;
        state_r      <= ST_SCAN;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_SCAN: begin
            if (ovl_s && alive_r[idx_r]) begin
              if (cy_in_s) begin
                scr_side_r[idx_r] <= 1'b1;
              end else begin
                scr_face_r[idx_r] <= 1'b1;
              end
            end
            if (idx_r == LAST_IDX) begin
              state_r <= ST_PADDLE;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
          ST_PADDLE: begin
            scr_paddle_r <= ovl_s;
            state_r      <= ST_COMMIT;
          end
          ST_COMMIT: begin
            coll_side_r   <= scr_side_r;
            coll_face_r   <= scr_face_r;
            paddle_hit_r  <= scr_paddle_r;
            alive_r       <= alive_next_s;
            all_cleared_r <= (alive_next_s == 16'h0000);
            scan_done_r   <= 1'b1;
            state_r       <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.collision_det = coll_side_r;
  assign bus.coll_y_det    = coll_face_r;
  assign bus.paddle_hit    = paddle_hit_r;
  assign bus.brick_alive   = alive_r;
  assign bus.all_cleared   = all_cleared_r;
  assign bus.scan_done     = scan_done_r;

endmodule

// File: tb/tb_ball_collision_det.sv
// Scoreboard bench for ball_collision_det: each position change pushes the
// modelled result, which is popped and compared when scan_done fires.
module tb_ball_collision_det;

  logic pclk = 1'b0;
  logic reset_n;

  ball_collision_det_if bus ();

  ball_collision_det dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0] side;
    logic [15:0] face;
    logic [15:0] alive;
    logic        paddle;
    logic        cleared;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_alive;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int px, input logic [15:0] alive);
    exp_t e;
    int bx0, bx1, by0, by1, rx0, ry0, i;
    e.side = 16'h0000;
    e.face = 16'h0000;
    bx0 = (x < 10) ? 0 : x - 10;
    bx1 = x + 10;
    by0 = (y < 10) ? 0 : y - 10;
    by1 = y + 10;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        i   = r * 4 + c;
        rx0 = 256 + c * 64;
        ry0 = 96 + r * 24;
        if (alive[i] && bx0 <= rx0 + 63 && bx1 >= rx0 && by0 <= ry0 + 23 && by1 >= ry0) begin
          if (y >= ry0 && y <= ry0 + 23) e.side[i] = 1'b1;
          else                           e.face[i] = 1'b1;
        end
      end
    end
    e.paddle  = (bx0 <= px + 127) && (bx1 >= px) && (by0 <= 751) && (by1 >= 740);
    e.alive   = alive & ~(e.side | e.face);
    e.cleared = (e.alive == 16'h0000);
    return e;
  endfunction

  task automatic drive_pos(input int x, input int y, input bit expect_commit);
    exp_t e;
    bus.x_pos = 12'(x);
    bus.y_pos = 12'(y);
    if (expect_commit) begin
      e = model(x, y, int'(bus.paddle_x), m_alive);
      m_alive = e.alive;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_commit(input string tag);
    int   k = 0;
    exp_t e;
    do begin
      @(posedge pclk);
      @(negedge pclk);
      k++;
    end while (!bus.scan_done && k < 40);
    check_val({tag, ".latency"}, 32'(k), 32'd19);
    check_val({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, ".collision_det"}, {16'd0, bus.collision_det}, {16'd0, e.side});
      check_val({tag, ".coll_y_det"}, {16'd0, bus.coll_y_det}, {16'd0, e.face});
      check_val({tag, ".paddle_hit"}, {31'd0, bus.paddle_hit}, {31'd0, e.paddle});
      check_val({tag, ".brick_alive"}, {16'd0, bus.brick_alive}, {16'd0, e.alive});
      check_val({tag, ".all_cleared"}, {31'd0, bus.all_cleared}, {31'd0, e.cleared});
    end
    @(posedge pclk);
    @(negedge pclk);
    check_val({tag, ".pulse_end"}, {31'd0, bus.scan_done}, 32'd0);
  endtask

  task automatic hit(input int x, input int y, input string tag);
    drive_pos(x, y, 1'b1);
    wait_commit(tag);
  endtask

  task automatic wait_quiet(input int n, input string tag);
    int cnt = 0;
    repeat (n) begin
      @(posedge pclk);
      @(negedge pclk);
      if (bus.scan_done) cnt++;
    end
    check_val(tag, 32'(cnt), 32'd0);
  endtask

  task automatic check_cleared_outputs(input string tag, input logic [15:0] exp_alive);
    check_val({tag, ".collision_det"}, {16'd0, bus.collision_det}, 32'd0);
    check_val({tag, ".coll_y_det"}, {16'd0, bus.coll_y_det}, 32'd0);
    check_val({tag, ".paddle_hit"}, {31'd0, bus.paddle_hit}, 32'd0);
    check_val({tag, ".scan_done"}, {31'd0, bus.scan_done}, 32'd0);
    check_val({tag, ".brick_alive"}, {16'd0, bus.brick_alive}, {16'd0, exp_alive});
    check_val({tag, ".all_cleared"}, {31'd0, bus.all_cleared}, 32'd0);
  endtask

  task automatic new_game_pulse(input string tag);
    bus.new_game = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    bus.new_game = 1'b0;
    m_alive = 16'hFFFF;
    check_cleared_outputs(tag, 16'hFFFF);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.new_game = 1'b0;
    bus.x_pos    = 12'd300;
    bus.y_pos    = 12'd0;
    bus.paddle_x = 12'd0;
    m_alive      = 16'hFFFF;
    repeat (2) @(negedge pclk);
    check_cleared_outputs("reset", 16'hFFFF);
    reset_n = 1'b1;
    wait_quiet(25, "idle_after_reset");

    hit(250, 108, "t1_side");
    new_game_pulse("ng1");

    hit(288, 88, "t2_face");
    hit(289, 88, "t2_dead");

    bus.paddle_x = 12'd400;
    hit(450, 732, "t3_paddle");
    hit(600, 732, "t3_miss");

    new_game_pulse("ng2");
    drive_pos(250, 108, 1'b0);
    wait_quiet(6, "t4_abort_quiet");
    hit(600, 108, "t4_restart");

    hit(320, 120, "multi");

    new_game_pulse("ng3");
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        hit(288 + c * 64, 108 + r * 24, $sformatf("t5_b%0d", r * 4 + c));
      end
    end
    new_game_pulse("ng4");
    wait_quiet(25, "ng_keeps_latch");

    hit(250, 108, "t6_pre");
    drive_pos(600, 108, 1'b0);
    wait_quiet(4, "t6_scan_quiet");
    @(posedge pclk);
    #2 reset_n = 1'b0;
    #1;
    m_alive = 16'hFFFF;
    check_cleared_outputs("t6_async_rst", 16'hFFFF);
    @(negedge pclk);
    bus.x_pos = 12'd300;
    bus.y_pos = 12'd0;
    @(negedge pclk);
    reset_n = 1'b1;
    wait_quiet(25, "t6_idle");
    hit(250, 108, "t6_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
